down_sample_loop_ctrl: RTL and testbench
========================================

# down_sample_loop_ctrl

Schedule controller for one operation port of the down_sample unified buffers (`hw_input_stencil_ub`, `avg_pool_stencil_clkwrk_dsa0_ub`, `avg_pool_stencil_ub`). It walks a 3-deep affine loop nest after a programmable start delay. Each iteration it drives the 4-entry `ctrl_vars` bus and the matching `wen`/`ren` strobe that the buffer consumes. One instance is placed per buffer port, and all instances share `flush` so that every op in the pipeline starts from a common time origin.

## Interface
Parameters:
- `EXT1`, default 4: extent of `ctrl_vars[1]` (outer loop, channel); must be ≥1.
- `EXT2`, default 32: extent of `ctrl_vars[2]` (middle loop, row); must be ≥1.
- `EXT3`, default 32: extent of `ctrl_vars[3]` (inner loop, column); must be ≥1.
- `DELAY`, default 0: cycles from `flush` to the first fire; range 0..65535.
- `II`, default 1: initiation interval, i.e. cycles between consecutive fires; range 1..65535.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset; asynchronous and active-high.
- `flush`, in, 1: synchronous start/restart pulse.
- `en`, in, 1: global advance enable; 0 means stall.
- `ctrl_vars`, out, 16×[3:0]: loop indices; `[0]` is the root and is constant 0.
- `valid`, out, 1: fire strobe; connects to the buffer `*_wen` or `*_ren`.
- `last`, out, 1: high together with `valid` on the final iteration.
- `busy`, out, 1: high in the DELAY or RUN state.
- `done`, out, 1: high in the DONE state.

## Operation
- FSM states:
  - IDLE: after reset; waits for `flush`.
  - DELAY: counts down the start delay.
  - RUN: issues iterations.
  - DONE: all iterations issued; holds until `flush`.
- Transitions:
  - IDLE/DONE → DELAY on `flush` when `DELAY` > 0; → RUN directly when `DELAY` = 0.
  - DELAY → RUN when the delay counter reaches 0 with `en`=1.
  - RUN → DONE on the edge following the fire where all indices are at their maximum.
- `flush` in any state (including DELAY and RUN) restarts:
  - all index counters, the II counter and the delay counter reload;
  - the next state is as for IDLE.
  - `flush` takes priority over every other event in the same cycle.
- Index order in RUN:
  - `ctrl_vars[3]` increments per fire and wraps EXT3−1 → 0.
  - On that wrap, `ctrl_vars[2]` increments and wraps EXT2−1 → 0.
  - On that wrap, `ctrl_vars[1]` increments.
- Total fires per flush = EXT1·EXT2·EXT3.
- `ctrl_vars` are registered and hold their last value between fires and in DONE. They return to 0 on reset or `flush`.
- II counter: `valid`=1 only in RUN when the II counter is 0. The counter then reloads to II−1 and counts down once per enabled cycle.
- `en`=0 freezes every counter and the FSM, and forces `valid`=0 and `last`=0. `flush` and `rst` are still honoured while `en`=0.
- Indices are 16-bit unsigned; extents never exceed 65535.

## Timing
- Reset values: FSM=IDLE, `ctrl_vars`=0, `valid`=0, `last`=0, `busy`=0, `done`=0. Reset takes effect immediately and asynchronously, including mid-RUN.
- Outputs are Moore/registered; there is no combinational path from `flush` or `en` to any output except the `en` gating of `valid`/`last`.
- Cycle numbering (`en`=1 throughout): `flush` is high in cycle 0.
  - First `valid` is in cycle 1+DELAY, with `ctrl_vars` = {0,0,0,0}.
  - Fire k (0-based) occurs in cycle 1+DELAY+k·II.
- `last` coincides with the final fire, where `ctrl_vars` = {0, EXT1−1, EXT2−1, EXT3−1}.
- `done` rises in the cycle after `last`; `busy` falls in the same cycle.
- A stall of s cycles delays every subsequent fire by exactly s.
- With EXT1=EXT2=EXT3=1, `valid` and `last` assert together once.

## Test plan
- Defaults (4,32,32, DELAY=0, II=1), `flush` in cycle 0:
  - `valid` high in cycles 1..4096 continuously;
  - cycle 33 shows {0,0,1,0};
  - cycle 4096 shows {0,3,31,31} with `last`=1;
  - `done`=1 from cycle 4097.
- DELAY=5, II=3, extents 2,2,2:
  - fires in cycles 6,9,…,27 (8 fires);
  - `busy`=1 in cycles 1..27; `done` from cycle 28.
- Stall: defaults with `en`=0 in cycles 10..12:
  - `valid`=0 in those cycles;
  - `ctrl_vars` held at {0,0,0,9};
  - the fire in cycle 13 shows {0,0,0,9}; `last` moves to cycle 4099.
- Restart: `flush` again in cycle 100 during RUN:
  - cycle 101 shows {0,0,0,0} with `valid`=1;
  - `last` occurs in cycle 4196.
- Reset mid-DELAY (DELAY=10, `rst` pulsed in cycle 4):
  - all outputs are 0 immediately;
  - no `valid` until the next `flush`.
- Single iteration (1,1,1): `valid`=`last`=1 in cycle 1 only; `done`=1 from cycle 2.

Source files
------------

// File: rtl/down_sample_loop_ctrl_if.sv
// Handshake bundle between a down_sample loop controller and its buffer port.
// The controller is the master: it takes flush/en and drives the schedule outputs.
interface down_sample_loop_ctrl_if;
    logic              flush;
    logic              en;
    logic [3:0][15:0]  ctrl_vars;
    logic              valid;
    logic              last;
    logic              busy;
    logic              done;

    modport master (
        input  flush,
        input  en,
        output ctrl_vars,
        output valid,
        output last,
        output busy,
        output done
    );

    modport slave (
        output flush,
        output en,
        input  ctrl_vars,
        input  valid,
        input  last,
        input  busy,
        input  done
    );
endinterface

// File: rtl/down_sample_loop_ctrl.sv
// Schedule controller for one down_sample buffer port: walks a 3-deep loop nest
// after a start delay, firing once every II enabled cycles.
module down_sample_loop_ctrl #(
    parameter int EXT1  = 4,
    parameter int EXT2  = 32,
    parameter int EXT3  = 32,
    parameter int DELAY = 0,
    parameter int II    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    down_sample_loop_ctrl_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

    localparam logic [15:0] MAX1     = 16'(EXT1 - 1);
    localparam logic [15:0] MAX2     = 16'(EXT2 - 1);
    localparam logic [15:0] MAX3     = 16'(EXT3 - 1);
    localparam logic [15:0] DLY_LOAD = 16'(DELAY - 1);
    localparam logic [15:0] II_LOAD  = 16'(II - 1);
    localparam state_t      START_ST = (DELAY == 0) ? S_RUN : S_DELAY;

    state_t      state_q, state_d;
    logic [15:0] idx1_q, idx1_d;
    logic [15:0] idx2_q, idx2_d;
    logic [15:0] idx3_q, idx3_d;
    logic [15:0] ii_q, ii_d;
    logic [15:0] dly_q, dly_d;
    logic        fire_q, fire_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        at_max;

    assign at_max = (idx1_q == MAX1) && (idx2_q == MAX2) && (idx3_q == MAX3);

    always_comb begin
        state_d = state_q;
        idx1_d  = idx1_q;
        idx2_d  = idx2_q;
        idx3_d  = idx3_q;
        ii_d    = ii_q;
        dly_d   = dly_q;

        if (bus.flush) begin
            state_d = START_ST;
            idx1_d  = '0;
            idx2_d  = '0;
            idx3_d  = '0;
            ii_d    = '0;
            dly_d   = DLY_LOAD;
        end else if (bus.en) begin
            unique case (state_q)
                S_DELAY: begin
                    if (dly_q == '0) state_d = S_RUN;
                    else             dly_d   = dly_q - 16'd1;
                end
                S_RUN: begin
                    if (ii_q == '0) begin
                        ii_d = II_LOAD;
                        // Indices freeze on the final fire so DONE shows the last tuple.
                        if (at_max) begin
                            state_d = S_DONE;
                        end else if (idx3_q != MAX3) begin
                            idx3_d = idx3_q + 16'd1;
                        end else begin
                            idx3_d = '0;
                            if (idx2_q != MAX2) begin
                                idx2_d = idx2_q + 16'd1;
                            end else begin
                                idx2_d = '0;
                                idx1_d = idx1_q + 16'd1;
                            end
                        end
                    end else begin
                        ii_d = ii_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end

        fire_d = (state_d == S_RUN) && (ii_d == '0);
        last_d = fire_d && (idx1_d == MAX1) && (idx2_d == MAX2) && (idx3_d == MAX3);
        busy_d = (state_d == S_DELAY) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx1_q  <= '0;
            idx2_q  <= '0;
            idx3_q  <= '0;
            ii_q    <= '0;
            dly_q   <= '0;
            fire_q  <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx1_q  <= idx1_d;
            idx2_q  <= idx2_d;
            idx3_q  <= idx3_d;
            ii_q    <= ii_d;
            dly_q   <= dly_d;
            fire_q  <= fire_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A stall only masks the strobes; fire_q/last_q hold and resume when en returns.
    assign bus.ctrl_vars = {idx3_q, idx2_q, idx1_q, 16'h0000};
    assign bus.valid     = fire_q & bus.en;
    assign bus.last      = last_q & bus.en;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_down_sample_loop_ctrl.sv
// Directed bench for down_sample_loop_ctrl: default schedule, delayed/II schedule,
// stall, restart, reset mid-delay and single-iteration nest.
module tb_down_sample_loop_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rst_c;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    down_sample_loop_ctrl_if ifa ();
    down_sample_loop_ctrl_if ifb ();
    down_sample_loop_ctrl_if ifc ();
    down_sample_loop_ctrl_if ifd ();

    down_sample_loop_ctrl u_a (.clk(clk), .rst(rst), .bus(ifa));

    down_sample_loop_ctrl #(.EXT1(2), .EXT2(2), .EXT3(2), .DELAY(5), .II(3))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    down_sample_loop_ctrl #(.DELAY(10))
        u_c (.clk(clk), .rst(rst_c), .bus(ifc));

    down_sample_loop_ctrl #(.EXT1(1), .EXT2(1), .EXT3(1))
        u_d (.clk(clk), .rst(rst), .bus(ifd));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] cv(input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'h0000};
    endfunction

    // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
    task automatic step(input int c);
        @(posedge clk);
        #2;
        cyc = c;
    endtask

    initial begin
        int k;
        rst = 1'b1;  rst_c = 1'b1;  cyc = -1;
        ifa.flush = 1'b0; ifa.en = 1'b1;
        ifb.flush = 1'b0; ifb.en = 1'b1;
        ifc.flush = 1'b0; ifc.en = 1'b1;
        ifd.flush = 1'b0; ifd.en = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_cv",    ifa.ctrl_vars, 64'h0);
        chk("rst_valid", ifa.valid, 1'b0);
        chk("rst_last",  ifa.last,  1'b0);
        chk("rst_busy",  ifa.busy,  1'b0);
        chk("rst_done",  ifa.done,  1'b0);
        rst = 1'b0; rst_c = 1'b0;
        step(-1); #1;
        chk("idle_valid", ifa.valid, 1'b0);

        // Defaults: 4096 back-to-back fires.
        step(0); ifa.flush = 1'b1;
        for (int c = 1; c <= 4100; c++) begin
            step(c); ifa.flush = 1'b0; #1;
            k = c - 1;
            chk("a_valid", ifa.valid, c <= 4096);
            chk("a_last",  ifa.last,  c == 4096);
            chk("a_busy",  ifa.busy,  c <= 4096);
            chk("a_done",  ifa.done,  c >= 4097);
            if (c <= 4096) chk("a_cv", ifa.ctrl_vars, cv(k / 1024, (k / 32) % 32, k % 32));
            if (c == 33)   chk("a_cv33", ifa.ctrl_vars, cv(0, 1, 0));
            if (c >= 4096) chk("a_cvhold", ifa.ctrl_vars, cv(3, 31, 31));
        end

        // Stall: en low in cycles 10..12.
        step(0); ifa.flush = 1'b1;
        for (int c = 1; c <= 4101; c++) begin
            step(c); ifa.flush = 1'b0;
            ifa.en = !(c >= 10 && c <= 12);
            #1;
            k = (c < 10) ? c - 1 : ((c <= 13) ? 9 : c - 4);
            chk("s_valid", ifa.valid, (c <= 4099) && !(c >= 10 && c <= 12));
            chk("s_last",  ifa.last,  c == 4099);
            chk("s_done",  ifa.done,  c >= 4100);
            if (c <= 4099) chk("s_cv", ifa.ctrl_vars, cv(k / 1024, (k / 32) % 32, k % 32));
            if (c >= 10 && c <= 13) chk("s_cvheld", ifa.ctrl_vars, cv(0, 0, 9));
        end
        ifa.en = 1'b1;

        // Restart: second flush in cycle 100 while running.
        step(0); ifa.flush = 1'b1;
        for (int c = 1; c <= 4200; c++) begin
            step(c); ifa.flush = (c == 100); #1;
            k = (c <= 100) ? c - 1 : c - 101;
            chk("r_valid", ifa.valid, c <= 4196);
            chk("r_last",  ifa.last,  c == 4196);
            chk("r_done",  ifa.done,  c >= 4197);
            if (c <= 4196) chk("r_cv", ifa.ctrl_vars, cv(k / 1024, (k / 32) % 32, k % 32));
            if (c == 101)  chk("r_cv101", ifa.ctrl_vars, cv(0, 0, 0));
        end

        // DELAY=5, II=3, 2x2x2 nest.
        step(0); ifb.flush = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            step(c); ifb.flush = 1'b0; #1;
            k = (c - 6) / 3;
            chk("b_valid", ifb.valid, (c >= 6) && (c <= 27) && ((c - 6) % 3 == 0));
            chk("b_last",  ifb.last,  c == 27);
            chk("b_busy",  ifb.busy,  c <= 27);
            chk("b_done",  ifb.done,  c >= 28);
            if (c >= 6 && c <= 27 && (c - 6) % 3 == 0)
                chk("b_cv", ifb.ctrl_vars, cv(k / 4, (k / 2) % 2, k % 2));
        end

        // Single iteration.
        step(0); ifd.flush = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(c); ifd.flush = 1'b0; #1;
            chk("d_valid", ifd.valid, c == 1);
            chk("d_last",  ifd.last,  c == 1);
            chk("d_busy",  ifd.busy,  c == 1);
            chk("d_done",  ifd.done,  c >= 2);
            chk("d_cv",    ifd.ctrl_vars, 64'h0);
        end

        // Reset mid-DELAY (DELAY=10), pulsed in cycle 4.
        step(0); ifc.flush = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step(c); ifc.flush = 1'b0; #1;
            chk("c_busy", ifc.busy, 1'b1);
            chk("c_valid", ifc.valid, 1'b0);
        end
        step(4); rst_c = 1'b1; #1;
        chk("c_rst_busy",  ifc.busy,  1'b0);
        chk("c_rst_done",  ifc.done,  1'b0);
        chk("c_rst_valid", ifc.valid, 1'b0);
        chk("c_rst_last",  ifc.last,  1'b0);
        chk("c_rst_cv",    ifc.ctrl_vars, 64'h0);
        step(5); rst_c = 1'b0;
        for (int c = 6; c <= 25; c++) begin
            step(c); #1;
            chk("c_quiet_valid", ifc.valid, 1'b0);
            chk("c_quiet_busy",  ifc.busy,  1'b0);
        end
        step(0); ifc.flush = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(c); ifc.flush = 1'b0; #1;
            chk("c2_valid", ifc.valid, c == 11 || c == 12);
            chk("c2_busy",  ifc.busy,  1'b1);
            if (c == 11) chk("c2_cv", ifc.ctrl_vars, cv(0, 0, 0));
            if (c == 12) chk("c2_cv", ifc.ctrl_vars, cv(0, 0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
